// File: rtl/sseg_scan_driver_if.sv
// Pin-side bundle for sseg_scan_driver: display data/control in, segment and
// anode drive plus frame_tick out. The driver uses the slave modport.
interface sseg_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] value;
  logic                  neg;
  logic                  load;
  logic                  enable;
  logic [N_DIGITS-1:0]   blink_mask;
  logic [6:0]            seg_n;
  logic [N_DIGITS-1:0]   an_n;
  logic                  frame_tick;

  modport master (
    output value, neg, load, enable, blink_mask,
    input  seg_n, an_n, frame_tick
  );

  modport slave (
    input  value, neg, load, enable, blink_mask,
    output seg_n, an_n, frame_tick
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment scan driver with frame-synchronous
// value update, guard interval and per-digit blink. Define SSEG_LZ_BLANK_EN for leading-zero blanking.
module sseg_scan_driver #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD_CYC = 1,
  parameter int BLINK_DIV = 1 << 24
) (
  input logic            clk,
  input logic            rst_n,
  sseg_scan_driver_if.slave bus
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int VW = 4 * N_DIGITS;

  localparam logic [SW-1:0]       SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]       GUARD_END  = SW'(GUARD_CYC);
  localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE     = {{(N_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [6:0]          SEG_DARK   = 7'h7F;
  localparam logic [6:0]          SEG_MINUS  = 7'h3F;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h18;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = SEG_DARK;
    endcase
    return g;
  endfunction

  logic [SW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]       digit_idx_q, digit_idx_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [VW-1:0]       pend_val_q, pend_val_d;
  logic                pend_neg_q, pend_neg_d;
  logic                pend_valid_q, pend_valid_d;
  logic [VW-1:0]       shadow_val_q, shadow_val_d;
  logic                shadow_neg_q, shadow_neg_d;
  logic [6:0]          seg_n_q, seg_n_d;
  logic [N_DIGITS-1:0] an_n_q, an_n_d;
  logic                frame_tick_q, frame_tick_d;

  logic                slot_wrap_s;
  logic                frame_end_s;
  logic [3:0]          cur_nib_s;
  logic                minus_s;
  logic                lz_blank_s;
  logic                dark_s;
`ifdef SSEG_LZ_BLANK_EN
  logic [IW-1:0]       lz_hi_s;
`endif

  // Scan/blink counters and the pending -> shadow value path.
  always_comb begin
    slot_wrap_s = (slot_cnt_q == SLOT_LAST);
    frame_end_s = slot_wrap_s && (digit_idx_q == IDX_LAST);

    if (slot_wrap_s) begin
      slot_cnt_d = '0;
    end else begin
      slot_cnt_d = slot_cnt_q + SW'(1);
    end

    if (frame_end_s) begin
      digit_idx_d = '0;
    end else if (slot_wrap_s) begin
      digit_idx_d = digit_idx_q + IW'(1);
    end else begin
      digit_idx_d = digit_idx_q;
    end

    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BW'(1);
      blink_phase_d = blink_phase_q;
    end

    // A load landing exactly on the frame boundary bypasses pending.
    pend_val_d   = pend_val_q;
    pend_neg_d   = pend_neg_q;
    pend_valid_d = pend_valid_q;
    shadow_val_d = shadow_val_q;
    shadow_neg_d = shadow_neg_q;
    if (frame_end_s) begin
      if (bus.load) begin
        shadow_val_d = bus.value;
        shadow_neg_d = bus.neg;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        shadow_val_d = pend_val_q;
        shadow_neg_d = pend_neg_q;
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d = pend_valid_q;
      end
    end else if (bus.load) begin
      pend_val_d   = bus.value;
      pend_neg_d   = bus.neg;
      pend_valid_d = 1'b1;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Next segment/anode drive for the digit currently being scanned.
  always_comb begin
    cur_nib_s = shadow_val_q[{digit_idx_q, 2'b00} +: 4];
    minus_s   = shadow_neg_q && (digit_idx_q == IDX_LAST);

`ifdef SSEG_LZ_BLANK_EN
    // The '-' digit never counts as a significant nibble nor gets blanked.
    lz_hi_s = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if ((shadow_val_q[4*i +: 4] != 4'h0) && !(shadow_neg_q && (i == N_DIGITS - 1))) begin
        lz_hi_s = IW'(i);
      end else begin
        lz_hi_s = lz_hi_s;
      end
    end
    lz_blank_s = (digit_idx_q > lz_hi_s) && !minus_s;
`else
    lz_blank_s = 1'b0;
`endif

    dark_s = (slot_cnt_q < GUARD_END) || !bus.enable ||
             (bus.blink_mask[digit_idx_q] && blink_phase_q) || lz_blank_s;

    if (dark_s) begin
      an_n_d  = '1;
      seg_n_d = SEG_DARK;
    end else if (minus_s) begin
      an_n_d  = ~(AN_ONE << digit_idx_q);
      seg_n_d = SEG_MINUS;
    end else begin
      an_n_d  = ~(AN_ONE << digit_idx_q);
      seg_n_d = hex_glyph(cur_nib_s);
    end

    frame_tick_d = frame_end_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_val_q    <= '0;
      pend_neg_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      shadow_val_q  <= '0;
      shadow_neg_q  <= 1'b0;
      seg_n_q       <= SEG_DARK;
      an_n_q        <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_val_q    <= pend_val_d;
      pend_neg_q    <= pend_neg_d;
      pend_valid_q  <= pend_valid_d;
      shadow_val_q  <= shadow_val_d;
      shadow_neg_q  <= shadow_neg_d;
      seg_n_q       <= seg_n_d;
      an_n_q        <= an_n_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign bus.seg_n      = seg_n_q;
  assign bus.an_n       = an_n_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (4 digits, 4-cycle slots, guard 1,
// blink 16); expected displays come from a glyph table and a load scoreboard.
module tb_sseg_scan_driver;

  localparam int ND = 4;

  logic clk;
  logic rst_n;

  sseg_scan_driver_if #(.N_DIGITS(ND)) bus ();

  sseg_scan_driver #(
    .N_DIGITS (ND),
    .SCAN_DIV (4),
    .GUARD_CYC(1),
    .BLINK_DIV(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      lit;
    logic [3:0][6:0] seg;
  } disp_t;

  typedef struct {
    logic [15:0] value;
    logic        neg;
    disp_t       exp;
  } vec_t;

`ifdef SSEG_LZ_BLANK_EN
  localparam logic [3:0] LIT_NEG5 = 4'b1001;
  localparam logic [3:0] LIT_D0   = 4'b0001;
`else
  localparam logic [3:0] LIT_NEG5 = 4'b1111;
  localparam logic [3:0] LIT_D0   = 4'b1111;
`endif

  vec_t  tbl [8];
  vec_t  nov;
  disp_t sb_q [$];
  disp_t cur;
  int    n_cmp = 0;
  int    n_err = 0;
  int    k     = 0;

  function automatic vec_t mk(input logic [15:0] v, input logic n, input logic [3:0] lit,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    vec_t r;
    r.value   = v;
    r.neg     = n;
    r.exp.lit = lit;
    r.exp.seg = {s3, s2, s1, s0};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got %0h expected %0h", name, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    sb_q.delete();
    cur.lit = 4'hF;
    cur.seg = {7'h40, 7'h40, 7'h40, 7'h40};
  endtask

  // One clock: optionally strobe load, predict the registered outputs, compare at negedge.
  task automatic step(input bit ld, input vec_t v);
    logic [3:0] an_e;
    logic [6:0] seg_e;
    bit         ft_e;
    bit         ph;
    int         s;
    int         slot;
    int         idx;
    bus.load = ld;
    if (ld) begin
      bus.value = v.value;
      bus.neg   = v.neg;
      sb_q.push_back(v.exp);
    end
    @(posedge clk);
    s    = k;
    k    = k + 1;
    slot = s % 4;
    idx  = (s / 4) % 4;
    ph   = ((s / 16) % 2) == 1;
    if (slot == 0 || !bus.enable || (bus.blink_mask[idx] && ph) || !cur.lit[idx]) begin
      an_e  = 4'hF;
      seg_e = 7'h7F;
    end else begin
      an_e  = ~(4'b0001 << idx);
      seg_e = cur.seg[idx];
    end
    ft_e = (s % 16) == 15;
    if (ft_e) begin
      while (sb_q.size() > 0) cur = sb_q.pop_front();
    end
    @(negedge clk);
    check("an_n", 32'(bus.an_n), 32'(an_e));
    check("seg_n", 32'(bus.seg_n), 32'(seg_e));
    check("frame_tick", 32'(bus.frame_tick), 32'(ft_e));
    bus.load = 1'b0;
  endtask

  initial begin
    tbl[0] = mk(16'h12AF, 1'b0, 4'hF,     7'h79, 7'h24, 7'h08, 7'h0E);
    tbl[1] = mk(16'h0005, 1'b1, LIT_NEG5, 7'h3F, 7'h40, 7'h40, 7'h12);
    tbl[2] = mk(16'h3456, 1'b0, 4'hF,     7'h30, 7'h19, 7'h12, 7'h02);
    tbl[3] = mk(16'h789B, 1'b0, 4'hF,     7'h78, 7'h00, 7'h18, 7'h03);
    tbl[4] = mk(16'hCDE0, 1'b0, 4'hF,     7'h46, 7'h21, 7'h06, 7'h40);
    tbl[5] = mk(16'h0000, 1'b0, LIT_D0,   7'h40, 7'h40, 7'h40, 7'h40);
    tbl[6] = mk(16'h0005, 1'b0, LIT_D0,   7'h40, 7'h40, 7'h40, 7'h12);
    tbl[7] = mk(16'h0900, 1'b1, 4'hF,     7'h3F, 7'h18, 7'h40, 7'h40);
    nov    = mk(16'h0000, 1'b0, 4'hF,     7'h40, 7'h40, 7'h40, 7'h40);

    rst_n          = 1'b0;
    bus.value      = 16'h0000;
    bus.neg        = 1'b0;
    bus.load       = 1'b0;
    bus.enable     = 1'b1;
    bus.blink_mask = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_an_n", 32'(bus.an_n), 32'h0000_000F);
    check("reset_seg_n", 32'(bus.seg_n), 32'h0000_007F);
    check("reset_frame_tick", 32'(bus.frame_tick), 32'h0000_0000);
    rst_n = 1'b1;
    model_reset();

    // Idle scan: zeros on every digit.
    for (int j = 0; j < 32; j++) step(1'b0, nov);

    // Table: load mid-frame, old digits persist until the boundary.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 32; j++) step(j == 6, tbl[i]);
    end

    // Two loads in one frame: the second wins.
    for (int j = 0; j < 32; j++) begin
      if (j == 3) step(1'b1, tbl[2]);
      else        step(j == 9, tbl[3]);
    end

    // Load in the boundary cycle shows in the very next frame.
    for (int j = 0; j < 32; j++) step(j == 15, tbl[4]);

    // Blink digit 0.
    bus.blink_mask = 4'b0001;
    for (int j = 0; j < 64; j++) step(1'b0, nov);
    bus.blink_mask = 4'b0000;

    // enable dropped mid-slot for three cycles.
    for (int j = 0; j < 32; j++) begin
      bus.enable = !(j >= 5 && j < 8);
      step(1'b0, nov);
    end
    bus.enable = 1'b1;

    // Reset mid-frame while a digit is lit: dark at once, shadow cleared.
    for (int j = 0; j < 7; j++) step(j == 2, tbl[0]);
    for (int j = 0; j < 16; j++) step(j == 1, tbl[3]);
    rst_n = 1'b0;
    #1;
    check("midrst_an_n", 32'(bus.an_n), 32'h0000_000F);
    check("midrst_seg_n", 32'(bus.seg_n), 32'h0000_007F);
    check("midrst_frame_tick", 32'(bus.frame_tick), 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int j = 0; j < 32; j++) step(1'b0, nov);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
